// File: rtl/sd_wrrmuxn_pkt_if.sv
// Bundle for the packet WRR mux: N producer channels in, one consumer channel out.
// master = producers + downstream sink (the environment); slave = the arbiter.
interface sd_wrrmuxn_pkt_if #(
  parameter int inputs    = 4,
  parameter int width     = 8,
  parameter int weight_sz = 4
);
  logic [inputs*width-1:0]     c_data;
  logic [inputs-1:0]           c_eop;
  logic [inputs-1:0]           c_srdy;
  logic [inputs-1:0]           c_drdy;
  logic [inputs*weight_sz-1:0] c_weight;
  logic [width-1:0]            p_data;
  logic                        p_eop;
  logic                        p_srdy;
  logic                        p_drdy;
  logic [inputs-1:0]           p_grant;

  modport master (
    output c_data, c_eop, c_srdy, c_weight, p_drdy,
    input  c_drdy, p_data, p_eop, p_srdy, p_grant
  );
  modport slave (
    input  c_data, c_eop, c_srdy, c_weight, p_drdy,
    output c_drdy, p_data, p_eop, p_srdy, p_grant
  );
endinterface

// File: rtl/sd_wrrmuxn_pkt.sv
// Packet-aware weighted round-robin mux: grant held from first beat to eop,
// up to c_weight[i] packets per input per round, combinational datapath.
module sd_wrrmuxn_pkt #(
  parameter  int inputs    = 4,
  parameter  int width     = 8,
  parameter  int weight_sz = 4,
  localparam int ptr_sz    = $clog2(inputs)
) (
  input logic              clk,
  input logic              reset,
  sd_wrrmuxn_pkt_if.slave  bus
);
  typedef enum logic {IDLE, LOCKED} lock_e;

  lock_e                               lock_q, lock_d;
  logic [ptr_sz-1:0]                   sel_q, sel_d, last_q, last_d, sel;
  logic [inputs-1:0][weight_sz-1:0]    credit_q, credit_d, eff_w;
  logic                                reload_q, reload_d;
  logic [inputs-1:0]                   elig;
  logic [ptr_sz-1:0]                   rr_elig, rr_req;
  logic                                f_elig, f_req, reload_now, do_reload;
  logic                                xfer, eop_xfer;
  int                                  idx;

  // Arbitration: stick with last_q while it has credit, else RR from last_q+1.
  always_comb begin
    idx        = 0;
    rr_elig    = last_q;
    rr_req     = last_q;
    f_elig     = 1'b0;
    f_req      = 1'b0;
    reload_now = 1'b0;
    for (int i = 0; i < inputs; i++) begin
      eff_w[i] = (bus.c_weight[i*weight_sz +: weight_sz] == '0) ?
                 weight_sz'(1) : bus.c_weight[i*weight_sz +: weight_sz];
      elig[i]  = bus.c_srdy[i] & (credit_q[i] != '0);
    end
    for (int k = 1; k <= inputs; k++) begin
      idx = (int'(last_q) + k) % inputs;
      if (!f_elig && elig[idx]) begin
        f_elig  = 1'b1;
        rr_elig = ptr_sz'(idx);
      end
      if (!f_req && bus.c_srdy[idx]) begin
        f_req  = 1'b1;
        rr_req = ptr_sz'(idx);
      end
    end
    if (lock_q == LOCKED)  sel = sel_q;
    else if (elig[last_q]) sel = last_q;
    else if (f_elig)       sel = rr_elig;
    else if (f_req) begin
      sel        = rr_req;
      reload_now = 1'b1;
    end
    else                   sel = last_q;
  end

  always_comb begin
    bus.p_data  = bus.c_data[int'(sel)*width +: width];
    bus.p_eop   = bus.c_eop[sel];
    bus.p_srdy  = bus.c_srdy[sel];
    bus.p_grant = '0;
    if (bus.p_srdy) bus.p_grant[sel] = 1'b1;
    bus.c_drdy  = bus.p_grant & {inputs{bus.p_drdy}};
  end

  assign xfer     = bus.p_srdy & bus.p_drdy;
  assign eop_xfer = xfer & bus.p_eop;
  // A reload chosen at the first beat of a multi-beat packet is applied at its eop.
  assign do_reload = (lock_q == LOCKED) ? reload_q : reload_now;

  always_comb begin
    lock_d   = lock_q;
    sel_d    = sel_q;
    last_d   = last_q;
    credit_d = credit_q;
    reload_d = reload_q;
    case (lock_q)
      IDLE: if (bus.p_srdy && !eop_xfer) begin
        lock_d   = LOCKED;
        sel_d    = sel;
        reload_d = reload_now;
      end
      LOCKED: if (eop_xfer) begin
        lock_d   = IDLE;
        reload_d = 1'b0;
      end
      default: lock_d = IDLE;
    endcase
    if (eop_xfer) begin
      last_d = sel;
      if (do_reload) begin
        credit_d      = eff_w;
        credit_d[sel] = eff_w[sel] - weight_sz'(1);
      end else if (credit_q[sel] != '0) begin
        credit_d[sel] = credit_q[sel] - weight_sz'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q   <= IDLE;
      sel_q    <= '0;
      last_q   <= ptr_sz'(inputs - 1);
      credit_q <= '0;
      reload_q <= 1'b0;
    end else begin
      lock_q   <= lock_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      credit_q <= credit_d;
      reload_q <= reload_d;
    end
  end
endmodule
